// File: rtl/adder_ctrl_pkg.sv
// Shared types and widths for the adder request arbiter and its round-robin picker.
package adder_ctrl_pkg;

    localparam int ADDER_W   = 4;
    localparam int GRANT_W   = 2;
    localparam int TIMEOUT_W = 4;

    typedef enum logic [2:0] {
        ARB,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NREQ-1:0]    grant,
    output logic [GRANT_W-1:0] idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = GRANT_W'(cand);
            end
        end
    end

endmodule

// File: rtl/adder_req_arbiter.sv
// Shares one state-machine adder among NREQ requesters: arbitrate, load A, load B,
// wait for the result (with timeout), then hold the response until the owner accepts it.
module adder_req_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [ADDER_W*NREQ-1:0]   req_a,
    input  logic [ADDER_W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]           resp_valid,
    input  logic [NREQ-1:0]           resp_ready,
    output logic [ADDER_W-1:0]        resp_sum,
    output logic                      resp_carry,
    output logic                      resp_err,
    output logic [ADDER_W-1:0]        adder_data,
    output logic                      adder_load_a,
    output logic                      adder_load_b,
    input  logic [ADDER_W-1:0]        adder_sum,
    input  logic                      adder_carry,
    input  logic                      adder_ready,
    output logic                      busy,
    output logic [GRANT_W-1:0]        grant_id
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is only offered in ARB; resp_valid only in RESP, to the granted requester.

    state_t               state;
    state_t               state_next;
    logic [GRANT_W-1:0]   ptr_q;
    logic [GRANT_W-1:0]   grant_q;
    logic [ADDER_W-1:0]   a_q;
    logic [ADDER_W-1:0]   b_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [ADDER_W-1:0]   sum_q;
    logic                 carry_q;
    logic                 err_q;

    logic [NREQ-1:0]      arb_grant;
    logic [GRANT_W-1:0]   arb_idx;
    logic [NREQ-1:0]      grant_mask;
    logic                 accept;
    logic                 resp_fire;
    logic                 timed_out;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign grant_mask = NREQ'(1) << grant_q;
    assign accept     = (state == ARB) && (|arb_grant);
    assign resp_fire  = (state == RESP) && (|(resp_ready & grant_mask));
    assign timed_out  = (cnt_q == TIMEOUT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (accept) state_next = LOAD_A;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = WAIT;
            WAIT:    if (adder_ready || timed_out) state_next = RESP;
            RESP:    if (resp_fire) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        req_ready    = (state == ARB) ? arb_grant : '0;
        resp_valid   = (state == RESP) ? grant_mask : '0;
        resp_sum     = (state == RESP) ? sum_q : '0;
        resp_carry   = (state == RESP) && carry_q;
        resp_err     = (state == RESP) && err_q;
        adder_load_a = (state == LOAD_A);
        adder_load_b = (state == LOAD_B);
        adder_data   = '0;
        if (state == LOAD_A) adder_data = a_q;
        if (state == LOAD_B) adder_data = b_q;
        busy         = (state != ARB);
        grant_id     = grant_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= req_a[ADDER_W*arb_idx +: ADDER_W];
                b_q     <= req_b[ADDER_W*arb_idx +: ADDER_W];
                grant_q <= arb_idx;
            end
            if (state == LOAD_B) cnt_q <= '0;
            // A ready adder wins over a timeout reached in the same cycle.
            if (state == WAIT) begin
                if (adder_ready) begin
                    sum_q   <= adder_sum;
                    carry_q <= adder_carry;
                    err_q   <= 1'b0;
                end else if (timed_out) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    err_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (resp_fire) begin
                ptr_q <= (grant_q == GRANT_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_req_arbiter.sv
// Directed bench for adder_req_arbiter with NREQ=4, TIMEOUT=3 and a behavioural 4-bit adder.
module tb_adder_req_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [3:0]  resp_sum;
    logic        resp_carry;
    logic        resp_err;
    logic [3:0]  adder_data;
    logic        adder_load_a;
    logic        adder_load_b;
    logic [3:0]  adder_sum;
    logic        adder_carry;
    logic        adder_ready;
    logic        busy;
    logic [1:0]  grant_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard entry: {requester id[1:0], err, carry, sum[3:0]}
    logic [7:0] exp_q[$];
    int         exp_ids[8];

    adder_req_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_sum     (resp_sum),
        .resp_carry   (resp_carry),
        .resp_err     (resp_err),
        .adder_data   (adder_data),
        .adder_load_a (adder_load_a),
        .adder_load_b (adder_load_b),
        .adder_sum    (adder_sum),
        .adder_carry  (adder_carry),
        .adder_ready  (adder_ready),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- adder model ----------------
    logic [3:0] ma, mb;
    logic       m_result;
    logic       stuck = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma       <= '0;
            mb       <= '0;
            m_result <= 1'b0;
        end else if (adder_load_a) begin
            ma       <= adder_data;
            m_result <= 1'b0;
        end else if (adder_load_b) begin
            mb       <= adder_data;
            m_result <= 1'b1;
        end else begin
            m_result <= 1'b0;
        end
    end

    assign {adder_carry, adder_sum} = m_result ? ({1'b0, ma} + {1'b0, mb}) : 5'd0;
    assign adder_ready = m_result & ~stuck;

    // ---------------- checking ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [1:0] mon_id;
    logic [7:0] mon_e;

    always @(negedge clk) begin
        if (!rst && ((resp_valid & resp_ready) != 4'b0)) begin
            mon_id = 2'd0;
            for (int i = 0; i < NREQ; i++) if (resp_valid[i]) mon_id = 2'(i);
            check_val("resp_onehot", 32'($onehot(resp_valid)), 32'd1);
            if (exp_q.size() == 0) begin
                check_val("resp_unexpected", {mon_id, resp_err, resp_carry, resp_sum}, 32'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("resp_data", {mon_id, resp_err, resp_carry, resp_sum}, mon_e);
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return {req_ready, resp_valid, resp_sum, resp_carry, resp_err,
                adder_data, adder_load_a, adder_load_b, busy, grant_id};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b);
        bit seen;
        @(posedge clk); #1;
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        req_valid[id]    = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        check_val("issue_accept", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check_val("wait_idle", 32'(done), 32'd1);
    endtask

    // Hold the requesters in mask valid until n grants; check order and 5-cycle spacing.
    task automatic stream(input logic [3:0] mask, input int n);
        int accepts;
        int prev;
        accepts = 0;
        prev    = 0;
        @(posedge clk); #1;
        req_valid = mask;
        for (int t = 0; t < 200 && accepts < n; t++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 4'b0) begin
                check_val("stream_grant", req_ready, 32'(4'b0001 << exp_ids[accepts]));
                if (accepts > 0) check_val("stream_spacing", cyc - prev, 5);
                prev = cyc;
                accepts++;
            end
        end
        check_val("stream_count", accepts, n);
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    // ---------------- stimulus ----------------
    int  n_cyc;
    bit  got;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 3 + 4 with cycle-by-cycle protocol checks
        exp_q.push_back({2'd0, 1'b0, 1'b0, 4'd7});
        @(posedge clk); #1;
        req_a[3:0]   = 4'd3;
        req_b[3:0]   = 4'd4;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check_val("c0_req_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_val("c1_load_a", {busy, adder_load_a, adder_load_b, adder_data}, {1'b1, 1'b1, 1'b0, 4'd3});
        @(negedge clk);
        check_val("c2_load_b", {adder_load_a, adder_load_b, adder_data}, {1'b0, 1'b1, 4'd4});
        @(negedge clk);
        check_val("c3_wait", {adder_load_a, adder_load_b, adder_data, resp_valid}, 10'd0);
        @(negedge clk);
        check_val("c4_resp_valid", resp_valid, 4'b0001);
        wait_idle();

        // Overflow cases
        exp_q.push_back({2'd0, 1'b0, 1'b1, 4'd0});
        issue(0, 4'd15, 4'd1);
        wait_idle();
        exp_q.push_back({2'd1, 1'b0, 1'b1, 4'd2});
        issue(1, 4'd9, 4'd9);
        wait_idle();

        // Fairness between requesters 0 and 1; pointer sits at 2 so 0 wins first
        req_a[3:0] = 4'd2;  req_b[3:0] = 4'd5;
        req_a[7:4] = 4'd10; req_b[7:4] = 4'd7;
        exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 0; exp_ids[3] = 1;
        exp_q.push_back({2'd0, 1'b0, 1'b0, 4'd7});
        exp_q.push_back({2'd1, 1'b0, 1'b1, 4'd1});
        exp_q.push_back({2'd0, 1'b0, 1'b0, 4'd7});
        exp_q.push_back({2'd1, 1'b0, 1'b1, 4'd1});
        stream(4'b0011, 4);
        wait_idle();

        // All four requesting from pointer 2: order 2,3,0,1,2 shows the wrap
        req_a = {4'd8, 4'd5, 4'd2, 4'd1};
        req_b = {4'd7, 4'd6, 4'd3, 4'd2};
        exp_ids[0] = 2; exp_ids[1] = 3; exp_ids[2] = 0; exp_ids[3] = 1; exp_ids[4] = 2;
        exp_q.push_back({2'd2, 1'b0, 1'b0, 4'd11});
        exp_q.push_back({2'd3, 1'b0, 1'b0, 4'd15});
        exp_q.push_back({2'd0, 1'b0, 1'b0, 4'd3});
        exp_q.push_back({2'd1, 1'b0, 1'b0, 4'd5});
        exp_q.push_back({2'd2, 1'b0, 1'b0, 4'd11});
        stream(4'b1111, 5);
        wait_idle();

        // Response back-pressure: only a non-granted resp_ready is high
        resp_ready = 4'b0001;
        exp_q.push_back({2'd1, 1'b0, 1'b0, 4'd13});
        issue(1, 4'd6, 4'd7);
        req_a[3:0]   = 4'd4;
        req_b[3:0]   = 4'd4;
        req_valid[0] = 1'b1;
        exp_q.push_back({2'd0, 1'b0, 1'b0, 4'd8});
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (resp_valid != 4'b0) got = 1'b1;
        end
        check_val("bp_resp_seen", 32'(got), 32'd1);
        for (int n = 0; n < 6; n++) begin
            if (n > 0) @(negedge clk);
            check_val("bp_hold", {req_ready, resp_valid, resp_err, resp_carry, resp_sum},
                      {4'b0000, 4'b0010, 1'b0, 1'b0, 4'd13});
        end
        @(posedge clk); #1;
        resp_ready = 4'b1111;
        @(negedge clk);
        check_val("bp_release_resp", resp_valid, 4'b0010);
        @(negedge clk);
        check_val("bp_next_accept", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_idle();

        // Timeout: adder never ready; pointer at 1 so requester 2 gets in
        stuck = 1'b1;
        exp_q.push_back({2'd2, 1'b1, 1'b0, 4'd0});
        issue(2, 4'd5, 4'd5);
        n_cyc = 0;
        got   = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            n_cyc++;
            if (resp_valid != 4'b0) got = 1'b1;
        end
        check_val("timeout_latency", n_cyc, 3 + TIMEOUT + 1);
        wait_idle();
        stuck = 1'b0;

        // Reset pulse during LOAD_B drops the in-flight request
        @(posedge clk); #1;
        req_a[15:12]  = 4'd2;
        req_b[15:12]  = 4'd3;
        req_valid[3]  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[3]) got = 1'b1;
        end
        check_val("rst_pre_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_in_load_b", {adder_load_b, adder_data}, {1'b1, 4'd3});
        #1 rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_outputs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back({2'd3, 1'b0, 1'b0, 4'd5});
        issue(3, 4'd2, 4'd3);
        wait_idle();

        check_val("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_req_arbiter.md
# adder_req_arbiter

Controller and round-robin arbiter that shares one 4-bit state-machine adder between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block sequences the adder through its load-A / load-B / result protocol and returns sum, carry and an error flag on a per-requester response handshake. It sits between the client logic and the adder's ui_in/uo_out pins, and is the only driver of the adder's control inputs.

## Interface
- NREQ, 2, number of requesters (legal range 2..4)
- TIMEOUT, 7, maximum cycles in WAIT without adder_ready before an error response (1..15)

- clk  in  1  single clock, all flops rising-edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  4*NREQ  operand A, requester i at [4i+3:4i]
- req_b  in  4*NREQ  operand B, same packing
- resp_valid  out  NREQ  per-requester response valid; at most one bit high
- resp_ready  in  NREQ  per-requester response accept
- resp_sum  out  4  sum for the requester whose resp_valid is high
- resp_carry  out  1  carry out
- resp_err  out  1  1 = adder timed out; sum/carry forced to 0
- adder_data  out  4  to adder data input
- adder_load_a  out  1  to adder load_a
- adder_load_b  out  1  to adder load_b
- adder_sum  in  4  from adder sum
- adder_carry  in  1  from adder carry
- adder_ready  in  1  from adder ready flag
- busy  out  1  high in every state except ARB
- grant_id  out  2  index of the current or last granted requester

## Operation
- States: ARB, LOAD_A, LOAD_B, WAIT, RESP.
- Reset values: state ARB, rr pointer 0, grant_id 0, all valid/ready/load outputs 0, resp_* 0, adder_data 0.
- **ARB**
  - req_ready is one-hot, combinational from req_valid.
  - Priority search starts at the rr pointer and wraps modulo NREQ.
  - On req_valid[i] & req_ready[i]: latch a, b and i; set grant_id = i; go to LOAD_A.
  - With no valid request, stay in ARB.
- **LOAD_A**: adder_data = a, adder_load_a = 1 for exactly one cycle; go to LOAD_B.
- **LOAD_B**: adder_data = b, adder_load_b = 1 for one cycle; clear the timeout counter; go to WAIT.
- **WAIT**
  - Both loads 0, adder_data 0. This returns the adder from RESULT to IDLE.
  - If adder_ready = 1: capture adder_sum and adder_carry, err = 0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: sum = 0, carry = 0, err = 1; go to RESP.
- **RESP**
  - resp_valid[grant_id] = 1; resp_sum, resp_carry and resp_err are held stable.
  - On resp_ready[grant_id]: rr pointer = (grant_id + 1) mod NREQ; go to ARB.
  - resp_ready bits of non-granted requesters are ignored.
- Arithmetic is performed only by the adder. The block neither checks nor recomputes the sum.
- Requesters hold req_a, req_b and req_valid stable until accepted. Dropping req_valid before acceptance is legal and has no effect.
- The adder's reset is rst, inverted, so both blocks reset together. A reset mid-operation returns everything to its reset values, and any in-flight request is lost without a response.

## Timing
- Acceptance edge is cycle 0: LOAD_A in cycle 1, LOAD_B in cycle 2, WAIT in cycle 3 (adder_ready is high there with a compliant adder).
- resp_valid rises in cycle 4.
- With resp_ready held high, back-to-back operations cost 5 cycles each (ARB, LOAD_A, LOAD_B, WAIT, RESP).
- A timeout response rises TIMEOUT+1 cycles after entering WAIT.
- If requests arrive in ARB and RESP cycles simultaneously, the request is taken only in the next ARB cycle. There is no accept during RESP.
- Only state-derived outputs are registered. req_ready is combinational from req_valid and the rr pointer.

## Structure
- Package adder_ctrl_pkg holds:
  - state enum
  - ADDER_W = 4
  - GRANT_W = 2
  - TIMEOUT_W = 4
- Sub-module rr_arbiter (parameter NREQ) provides:
  - inputs: req vector, pointer
  - outputs: one-hot grant, encoded index
- FSM, operand latches, timeout counter and response registers live in adder_req_arbiter.

## Test plan
- Reset, then requester 0 with a=3, b=4 → req_ready[0] in cycle 0, load_a with data 3 in cycle 1, load_b with data 4 in cycle 2, resp_valid[0] in cycle 4 with sum 7, carry 0, err 0.
- Overflow: a=15, b=1 → sum 0, carry 1; a=9, b=9 → sum 2, carry 1.
- Fairness: both req_valid held high, resp_ready tied 1 → grants alternate 0,1,0,1 with one response every 5 cycles; the rr pointer wraps at NREQ = 4.
- Response back-pressure: resp_ready low for 6 cycles → resp_valid and data held, req_ready stays 0 for all requesters, release on the first resp_ready cycle.
- Timeout: adder model with adder_ready stuck 0, TIMEOUT = 3 → resp_valid 4 cycles after entering WAIT, with err 1 and sum/carry 0.
- Reset pulse during LOAD_B → all outputs 0 on the next sample; a fresh request completes normally afterwards with the correct sum.
